// File: rtl/huffman_bit_packer_if.sv
// Symbol-in / chunk-out bundle for the Huffman bit packer.
// The slave side is the packer itself and the master side is whoever drives symbols and sinks chunks.
interface huffman_bit_packer_if #(
  parameter int OUT_W = 4
);
  logic [3:0]                     sym_data;
  logic                           sym_valid;
  logic                           sym_ready;
  logic                           flush;
  logic [OUT_W-1:0]               out_bits;
  logic [$clog2(OUT_W+1)-1:0]     out_len;
  logic                           out_valid;
  logic                           out_ready;
  logic                           flush_done;

  modport master (
    output sym_data, sym_valid, flush, out_ready,
    input  sym_ready, out_bits, out_len, out_valid, flush_done
  );

  modport slave (
    input  sym_data, sym_valid, flush, out_ready,
    output sym_ready, out_bits, out_len, out_valid, flush_done
  );
endinterface

// File: rtl/huffman_bit_packer.sv
// Prefix-encodes signed 4-bit symbols, packs the codes MSB-first and emits 1-4 bit chunks.
// The first full chunk is valid one cycle after the symbol is accepted; input stalls while 4+ bits are buffered or a flush runs.
module huffman_bit_packer #(
  parameter int MAX_CODE = 9,
  parameter int OUT_W    = 4,
  parameter int ACC_W    = MAX_CODE + OUT_W - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  huffman_bit_packer_if.slave  bus
);
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int LEN_W = $clog2(OUT_W + 1);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_out_bits;
  logic [LEN_W-1:0] r_out_len;
  logic             r_out_valid;
  logic             r_flush_done;

  logic [3:0]       w_neg;
  logic [2:0]       w_mag;
  logic [8:0]       w_code;
  logic [3:0]       w_len;
  logic [CNT_W-1:0] w_shift;
  logic [ACC_W-1:0] w_app;
  logic [OUT_W-1:0] w_part_bits;
  logic             w_free, w_take, w_pop, w_partial, w_done;

  // +-k sends k ones, a zero, then the sign; -8 is the all-ones 8-bit word
  always_comb begin
    w_neg  = 4'(~bus.sym_data + 4'd1);
    w_mag  = bus.sym_data[3] ? w_neg[2:0] : bus.sym_data[2:0];
    w_code = 9'd0;
    w_len  = 4'd1;
    if (bus.sym_data == 4'b1000) begin
      w_code = 9'h0FF;
      w_len  = 4'd8;
    end else if (bus.sym_data != 4'd0) begin
      w_code = (((9'd1 << w_mag) - 9'd1) << 2) | {8'd0, bus.sym_data[3]};
      w_len  = {1'b0, w_mag} + 4'd2;
    end
  end

  assign w_shift     = CNT_W'(ACC_W) - r_cnt - CNT_W'(w_len);
  assign w_app       = ACC_W'(w_code) << w_shift;
  assign w_part_bits = OUT_W'(r_acc >> (CNT_W'(ACC_W) - r_cnt));

  assign w_free    = !r_out_valid || bus.out_ready;
  assign w_take    = bus.sym_valid && bus.sym_ready;
  assign w_pop     = w_free && (r_cnt >= CNT_W'(OUT_W));
  assign w_partial = (r_state == ST_FLUSH) && w_free &&
                     (r_cnt != '0) && (r_cnt < CNT_W'(OUT_W));
  assign w_done    = (r_state == ST_FLUSH) && w_free && (r_cnt == '0);

  assign bus.sym_ready  = !reset && (r_cnt < CNT_W'(OUT_W)) && (r_state == ST_RUN);
  assign bus.out_bits   = r_out_bits;
  assign bus.out_len    = r_out_len;
  assign bus.out_valid  = r_out_valid;
  assign bus.flush_done = r_flush_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_out_bits   <= '0;
      r_out_len    <= '0;
      r_out_valid  <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      // append and pop never coincide: one needs cnt<4, the other cnt>=4
      if (w_take) begin
        r_acc <= r_acc | w_app;
        r_cnt <= r_cnt + CNT_W'(w_len);
      end else if (w_pop) begin
        r_acc <= r_acc << OUT_W;
        r_cnt <= r_cnt - CNT_W'(OUT_W);
      end else if (w_partial) begin
        r_acc <= '0;
        r_cnt <= '0;
      end

      if (w_pop) begin
        r_out_bits  <= r_acc[ACC_W-1 -: OUT_W];
        r_out_len   <= LEN_W'(OUT_W);
        r_out_valid <= 1'b1;
      end else if (w_partial) begin
        r_out_bits  <= w_part_bits;
        r_out_len   <= LEN_W'(r_cnt);
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (r_state == ST_RUN) begin
        if (bus.flush) r_state <= ST_FLUSH;
      end else if (w_done) begin
        r_state      <= ST_RUN;
        r_flush_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed and randomized checks of the Huffman bit packer against hand-computed chunks and a reference decoder.
module tb_huffman_bit_packer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rand_mode = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] q_bits[$];
  logic [2:0] q_len[$];
  logic       q_stream[$];

  huffman_bit_packer_if bus ();

  huffman_bit_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Chunks are captured half a cycle before the edge that consumes them
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      q_bits.push_back(bus.out_bits);
      q_len.push_back(bus.out_len);
      for (int b = int'(bus.out_len) - 1; b >= 0; b--) q_stream.push_back(bus.out_bits[b]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [3:0] s);
    bus.sym_data  = s;
    bus.sym_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.sym_ready) begin
        tick();
        bus.sym_valid = 1'b0;
        return;
      end
      tick();
    end
    check("send sym_ready timeout", 32'(bus.sym_ready), 32'd1);
    bus.sym_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (bus.flush_done) return;
      tick();
    end
    check("flush_done timeout", 32'(bus.flush_done), 32'd1);
  endtask

  task automatic check_chunk(input string tag, input int idx, input logic [3:0] eb, input logic [2:0] el);
    check({tag, " bits"}, (idx < q_bits.size()) ? 32'(q_bits[idx]) : 32'hFFFF, 32'(eb));
    check({tag, " len"},  (idx < q_len.size())  ? 32'(q_len[idx])  : 32'hFFFF, 32'(el));
  endtask

  function automatic int code_len(input logic [3:0] s);
    int v;
    v = int'($signed(s));
    if (v == 0)  return 1;
    if (v == -8) return 8;
    return ((v < 0) ? -v : v) + 2;
  endfunction

  initial begin
    int base;
    int idx;
    int k;
    int total;
    logic [3:0] sent[$];
    logic [3:0] dec[$];
    logic [3:0] s;

    bus.sym_data  = 4'd0;
    bus.sym_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst sym_ready", 32'(bus.sym_ready), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_bits", 32'(bus.out_bits), 32'd0);
    check("rst out_len", 32'(bus.out_len), 32'd0);
    check("rst flush_done", 32'(bus.flush_done), 32'd0);
    reset = 1'b0;
    #1;
    check("post-rst sym_ready", 32'(bus.sym_ready), 32'd1);

    // Symbol 0 then flush: a single 1-bit zero chunk
    base = q_bits.size();
    send(4'd0);
    do_flush();
    wait_done();
    check("s1 flush_done", 32'(bus.flush_done), 32'd1);
    check("s1 chunk count", 32'(q_bits.size() - base), 32'd1);
    check_chunk("s1 c0", base, 4'b0000, 3'd1);
    tick();
    check("s1 flush_done pulse", 32'(bus.flush_done), 32'd0);

    // +7 = 111111100
    base = q_bits.size();
    send(4'd7);
    do_flush();
    wait_done();
    check("s2 chunk count", 32'(q_bits.size() - base), 32'd3);
    check_chunk("s2 c0", base,     4'b1111, 3'd4);
    check_chunk("s2 c1", base + 1, 4'b1110, 3'd4);
    check_chunk("s2 c2", base + 2, 4'b0000, 3'd1);
    tick();

    // -1, +1, -8 = 101 100 11111111
    base = q_bits.size();
    send(4'hF);
    send(4'd1);
    send(4'h8);
    do_flush();
    wait_done();
    check("s3 chunk count", 32'(q_bits.size() - base), 32'd4);
    check_chunk("s3 c0", base,     4'b1011, 3'd4);
    check_chunk("s3 c1", base + 1, 4'b0011, 3'd4);
    check_chunk("s3 c2", base + 2, 4'b1111, 3'd4);
    check_chunk("s3 c3", base + 3, 4'b0011, 3'd2);
    tick();

    // +7 under backpressure
    base = q_bits.size();
    bus.out_ready = 1'b0;
    send(4'd7);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("s4 hold out_valid", 32'(bus.out_valid), 32'd1);
      check("s4 hold out_bits", 32'(bus.out_bits), 32'b1111);
      check("s4 hold sym_ready", 32'(bus.sym_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("s4 sym_ready after drain", 32'(bus.sym_ready), 32'd1);
    do_flush();
    wait_done();
    check("s4 chunk count", 32'(q_bits.size() - base), 32'd3);
    check_chunk("s4 c0", base,     4'b1111, 3'd4);
    check_chunk("s4 c1", base + 1, 4'b1110, 3'd4);
    check_chunk("s4 c2", base + 2, 4'b0000, 3'd1);
    tick();

    // -7 discarded by a reset, then an empty flush
    base = q_bits.size();
    send(4'h9);
    reset = 1'b1;
    tick();
    check("s5 rst sym_ready", 32'(bus.sym_ready), 32'd0);
    check("s5 rst out_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("s5 post-rst sym_ready", 32'(bus.sym_ready), 32'd1);
    do_flush();
    check("s5 flush_done early", 32'(bus.flush_done), 32'd0);
    tick();
    check("s5 flush_done", 32'(bus.flush_done), 32'd1);
    tick();
    check("s5 flush_done pulse", 32'(bus.flush_done), 32'd0);
    check("s5 no chunk", 32'(q_bits.size() - base), 32'd0);

    // 200 random symbols with random backpressure, decoded from the captured stream
    base = q_stream.size();
    total = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      s = 4'($urandom_range(0, 15));
      sent.push_back(s);
      total += code_len(s);
      send(s);
    end
    do_flush();
    wait_done();
    rand_mode = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("rand total bits", 32'(q_stream.size() - base), 32'(total));
    idx = base;
    while (idx < q_stream.size()) begin
      k = 0;
      while (k < 8 && idx < q_stream.size() && q_stream[idx] == 1'b1) begin
        k++;
        idx++;
      end
      if (k == 8) begin
        dec.push_back(4'h8);
      end else if (k == 0) begin
        idx++;
        dec.push_back(4'd0);
      end else begin
        idx++;
        dec.push_back((idx < q_stream.size() && q_stream[idx]) ? 4'(-k) : 4'(k));
        idx++;
      end
    end
    check("rand decoded count", 32'(dec.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size(); i++) begin
      check($sformatf("rand sym %0d", i), (i < dec.size()) ? 32'(dec[i]) : 32'hFFFF, 32'(sent[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

Transmit-side counterpart of the Huffman shift-register decoder. It encodes signed 4-bit symbols with a fixed 16-entry prefix code of at most 9 bits, packs the code bits MSB-first into an accumulator, and emits 1–4-bit chunks. The chunk format is exactly the one the decoder's `in_bits`/`in_len`/`sValid` input consumes. It sits between the residual generator and the serial/FIFO link that feeds the decoder.

## Interface
- `MAX_CODE`, 9: longest codeword in bits.
- `OUT_W`, 4: maximum chunk width in bits.
- `ACC_W`, `MAX_CODE+OUT_W-1` (12): accumulator width in bits.

Ports:
- `clk` in 1: sole clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sym_data` in 4: signed symbol, -8..7.
- `sym_valid` in 1: symbol offered.
- `sym_ready` out 1: symbol can be accepted this cycle.
- `flush` in 1: pulse requesting emission of residual (<4) bits.
- `out_bits` out 4: chunk; valid bits in `[out_len-1:0]`, first stream bit at `out_bits[out_len-1]`, unused upper bits 0.
- `out_len` out 3: valid bit count, 1..4.
- `out_valid` out 1: chunk valid.
- `out_ready` in 1: downstream accepts the chunk.
- `flush_done` out 1: one-cycle pulse when a flush completes.

## Operation
- Codebook (bits listed first-sent first; s = 0 for positive, 1 for negative):
  - 0 → `0`, length 1.
  - ±k for k = 1..7 → k ones, then `0`, then s; length k+2.
  - -8 → `11111111`, length 8.
- The codebook is complete (Kraft sum = 1) and prefix-free. It is computed arithmetically; a ROM is not required.
- Accumulator `acc[ACC_W-1:0]` is MSB-aligned and holds `cnt` valid bits (0..12).
- Append: `acc <= acc | (code << (ACC_W-cnt-len))`; `cnt += len`.
- `sym_ready = !reset && cnt<=3 && state==RUN`. A handshake happens when `sym_valid && sym_ready`.
- Output register is free when `!out_valid || out_ready`.
- Full chunk: if the output register is free and `cnt>=4`, load `out_bits = acc[11:8]`, `out_len = 4`, shift `acc` left by 4, and set `cnt -= 4`.
- Append (needs `cnt<=3`) and full-chunk pop (needs `cnt>=4`) are mutually exclusive, so `cnt` never goes below 0 or above 12.
- States:
  - RUN: normal operation. `flush` high → FLUSH. A symbol accepted in the same cycle as `flush` is included in the flush.
  - FLUSH: `sym_ready = 0`. Full chunks drain first.
    - When `1<=cnt<=3` and the output register is free, emit a partial chunk: `out_len = cnt`, `out_bits = acc[11:12-cnt]` right-aligned, then `cnt = 0`.
    - When `cnt==0` and (`!out_valid` or `out_ready`) → pulse `flush_done`, return to RUN.
  - `flush` asserted while in FLUSH is ignored.
- `out_bits` and `out_len` stay stable while `out_valid && !out_ready`.
- Reset mid-operation discards `acc` and any pending chunk; no partial chunk is emitted.

## Timing
- Reset values:
  - `out_valid = 0`, `out_bits = 0`, `out_len = 0`, `flush_done = 0`.
  - `cnt = 0`, `acc = 0`, state = RUN.
  - `sym_ready` is 0 while `reset` is high and 1 on the first cycle after it drops.
- Latency: a symbol accepted at edge N produces its first full chunk with `out_valid` high after edge N+1, provided `cnt>=4` and the output register is free.
- Throughput: with `out_ready` held at 1, one chunk per cycle. `sym_ready` deasserts whenever `cnt>=4`.
- Flush on an empty buffer: `flush` at edge N → FLUSH; `flush_done` is high in the cycle after edge N+1, with no chunk emitted.
- `flush_done` is a single-cycle pulse, registered.

## Test plan
- Reset, then symbol 0, then `flush` → one chunk with `out_bits = 4'b0000`, `out_len = 1`, then a `flush_done` pulse.
- Symbol +7 (`111111100`) with `out_ready = 1` → chunks `1111`/4 and `1110`/4. `flush` → `0000`/1, then `flush_done`.
- Symbols -1, +1, -8, then `flush` → chunks `1011`/4, `0011`/4, `1111`/4, `0011`/2.
- Symbol +7 with `out_ready = 0` for 5 cycles → `out_valid` held with `out_bits = 1111` stable and `sym_ready = 0`. Release `out_ready` → remaining chunks as in scenario 2, `sym_ready` returns to 1 once `cnt = 1`.
- Accept -7, then assert `reset` for 1 cycle, then `flush` → no chunk emitted; `flush_done` one cycle after FLUSH entry.
- 200 random symbols plus `flush`, chunks fed into the decoder → decoded sequence matches the input exactly; total bits equal the sum of code lengths.
